// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM pipeline ports, the arbiter and the memory macro.
// The master view is the arbiter; the slave view is the pipeline plus memory side.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_kill;
   logic              if_ack;
   logic [DATA_W-1:0] if_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  if_req, if_addr, if_kill, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output if_req, if_addr, if_kill, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported fixed-latency memory between the fetch and data ports.
// Optional fetch starvation guard is enabled by defining ARB_IF_STARVE_GUARD_EN.
module mem_port_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MEM_LAT  = 2,
   parameter int MAX_WAIT = 4
) (
   input  logic               clk,
   input  logic               rst,
   mem_port_arbiter_if.master bus,
   output logic               busy
);
   // state   | meaning
   // IDLE    | arbitrate between data and fetch requests
   // ISSUE   | mem_en strobe for the granted access
   // WAIT    | count down read latency, capture read data on the last cycle
   // RESP    | owner's ack pulse, then back to IDLE

   localparam int CNT_W = $clog2(MEM_LAT + 1);

   if (MEM_LAT < 1 || MAX_WAIT < 1) begin : g_param_check
      $error("mem_port_arbiter: MEM_LAT and MAX_WAIT must be at least 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t             state;
   state_t             state_nxt;
   logic               owner_i;
   logic               we_q;
   logic               kill_q;
   logic [CNT_W-1:0]   wait_cnt;
   logic               grant_i;
   logic               grant_d;
   logic               force_i;
   logic               kill_now;
   logic               capture;
   logic               to_resp;
   logic               mem_en_nxt;
   logic               mem_we_nxt;
   logic               if_ack_nxt;
   logic               d_ack_nxt;
   logic               busy_nxt;

`ifdef ARB_IF_STARVE_GUARD_EN
   localparam int SW = $clog2(MAX_WAIT + 1);
   logic [SW-1:0] starve_cnt;

   assign force_i = (starve_cnt == SW'(MAX_WAIT)) && bus.if_req && !bus.if_kill;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (grant_i || !bus.if_req) begin
         starve_cnt <= '0;
      end else if (grant_d && (starve_cnt != SW'(MAX_WAIT))) begin
         starve_cnt <= starve_cnt + SW'(1);
      end
   end
`else
   assign force_i = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      case (state)
         S_IDLE: begin
            if (force_i) begin
               grant_i = 1'b1;
            end else if (bus.d_req) begin
               grant_d = 1'b1;
            end else if (bus.if_req && !bus.if_kill) begin
               grant_i = 1'b1;
            end
            if (grant_i || grant_d) begin
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: state_nxt = we_q ? S_RESP : S_WAIT;
         S_WAIT:  if (wait_cnt == CNT_W'(1)) state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // A kill seen on the last WAIT cycle must already block the ack and the capture.
   assign kill_now = owner_i && (kill_q || bus.if_kill);
   assign capture  = (state == S_WAIT) && (wait_cnt == CNT_W'(1));

   always_comb begin
      to_resp    = (state_nxt == S_RESP) && (state != S_RESP);
      mem_en_nxt = grant_i || grant_d;
      mem_we_nxt = grant_d && bus.d_we;
      d_ack_nxt  = to_resp && !owner_i;
      if_ack_nxt = to_resp && owner_i && !kill_now;
      busy_nxt   = (state_nxt != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.if_ack    <= 1'b0;
         bus.d_ack     <= 1'b0;
         bus.if_rdata  <= '0;
         bus.d_rdata   <= '0;
         busy          <= 1'b0;
         owner_i       <= 1'b0;
         we_q          <= 1'b0;
         kill_q        <= 1'b0;
         wait_cnt      <= '0;
      end else begin
         bus.mem_en <= mem_en_nxt;
         bus.mem_we <= mem_we_nxt;
         bus.if_ack <= if_ack_nxt;
         bus.d_ack  <= d_ack_nxt;
         busy       <= busy_nxt;

         if (grant_i || grant_d) begin
            owner_i      <= grant_i;
            we_q         <= mem_we_nxt;
            bus.mem_addr <= grant_i ? bus.if_addr : bus.d_addr;
         end
         if (grant_d) begin
            bus.mem_wdata <= bus.d_wdata;
         end

         if ((state == S_ISSUE) && !we_q) begin
            wait_cnt <= CNT_W'(MEM_LAT);
         end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
         end

         if (state_nxt == S_IDLE) begin
            kill_q <= 1'b0;
         end else if ((state != S_IDLE) && owner_i && bus.if_kill) begin
            kill_q <= 1'b1;
         end

         if (capture && !owner_i) begin
            bus.d_rdata <= bus.mem_rdata;
         end
         if (capture && !kill_now && owner_i) begin
            bus.if_rdata <= bus.mem_rdata;
         end
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-schedule reference model,
// per-cycle compare, directed scenarios and randomized traffic.
module tb_mem_port_arbiter;
   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 32;
   localparam int MEM_LAT  = 2;
   localparam int MAX_WAIT = 4;
`ifdef ARB_IF_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic busy;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .MAX_WAIT(MAX_WAIT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [31:0] env_mem [64];
   logic [31:0] ref_mem [64];

   function automatic logic [31:0] init_word(int i);
      return 32'h5A00_0000 + (32'(i) * 32'h0001_0101);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Memory macro: writes land at the strobe, read data valid MEM_LAT cycles after it.
   int         pend = 0;
   logic [5:0] ridx = '0;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend = 0;
      end else begin
         if (pend > 0) pend--;
         if (bus.mem_en) begin
            if (bus.mem_we) env_mem[bus.mem_addr[7:2]] = bus.mem_wdata;
            else begin
               pend = MEM_LAT;
               ridx = bus.mem_addr[7:2];
            end
         end
      end
      bus.mem_rdata <= (pend == 1) ? env_mem[ridx] : $urandom;
   end

   // Reference model: each grant fixes its strobe, ack and next-free cycles arithmetically.
   int          cyc = 0, c = 0, n = 0;
   int          g = -100, ackc = -100, next_free = 0, scnt = 0;
   bit          own_i = 0, m_we = 0, killed = 0, gi = 0, gd = 0;
   logic [31:0] m_addr = '0, m_wdata = '0, rd_val = '0;
   logic        e_if_ack = 0, e_d_ack = 0, e_en = 0, e_we = 0, e_busy = 0;
   logic [31:0] e_addr = '0, e_wdata = '0, e_if_rdata = '0, e_d_rdata = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         g = -100; ackc = -100; next_free = 0; scnt = 0;
         own_i = 0; m_we = 0; killed = 0;
         e_if_ack = 0; e_d_ack = 0; e_en = 0; e_we = 0; e_busy = 0;
         e_if_rdata = '0; e_d_rdata = '0;
      end else begin
         c = cyc;
         n = cyc + 1;
         cyc++;
         if (own_i && bus.if_kill && (c >= g + 1) && (c <= ackc - 1)) killed = 1;
         gi = 0;
         gd = 0;
         if (c >= next_free) begin
            if (GUARD && (scnt >= MAX_WAIT) && bus.if_req && !bus.if_kill) gi = 1;
            else if (bus.d_req) gd = 1;
            else if (bus.if_req && !bus.if_kill) gi = 1;
         end
         if (gi || !bus.if_req) scnt = 0;
         else if (gd && (scnt < MAX_WAIT)) scnt++;
         if (gi || gd) begin
            g      = c;
            own_i  = gi;
            m_we   = gd && bus.d_we;
            m_addr = gi ? bus.if_addr : bus.d_addr;
            killed = 0;
            if (gd) m_wdata = bus.d_wdata;
            ackc      = g + 2 + (m_we ? 0 : MEM_LAT);
            next_free = ackc + 1;
            if (m_we) ref_mem[m_addr[7:2]] = m_wdata;
            else rd_val = ref_mem[m_addr[7:2]];
         end
         e_en     = (n == g + 1);
         e_we     = e_en && m_we;
         e_busy   = (n >= g + 1) && (n <= ackc);
         e_d_ack  = (n == ackc) && !own_i;
         e_if_ack = (n == ackc) && own_i && !killed;
         if (e_en) e_addr = m_addr;
         if (e_we) e_wdata = m_wdata;
         if ((n == ackc) && !m_we) begin
            if (!own_i) e_d_rdata = rd_val;
            else if (!killed) e_if_rdata = rd_val;
         end
      end
   end

   always @(negedge clk) begin
      chk("cmp_if_ack",   32'(bus.if_ack), 32'(e_if_ack));
      chk("cmp_d_ack",    32'(bus.d_ack),  32'(e_d_ack));
      chk("cmp_mem_en",   32'(bus.mem_en), 32'(e_en));
      chk("cmp_mem_we",   32'(bus.mem_we), 32'(e_we));
      chk("cmp_busy",     32'(busy),       32'(e_busy));
      chk("cmp_if_rdata", bus.if_rdata,    e_if_rdata);
      chk("cmp_d_rdata",  bus.d_rdata,     e_d_rdata);
      if (!rst) begin
         chk("cmp_rst_mem_addr",  bus.mem_addr,  32'h0);
         chk("cmp_rst_mem_wdata", bus.mem_wdata, 32'h0);
      end else begin
         if (e_en) chk("cmp_mem_addr", bus.mem_addr, e_addr);
         if (e_we) chk("cmp_mem_wdata", bus.mem_wdata, e_wdata);
      end
   end

   task automatic settle();
      int k = 0;
      bus.d_req   = 1'b0;
      bus.if_req  = 1'b0;
      bus.if_kill = 1'b0;
      while (busy && (k < 40)) begin
         @(posedge clk); #2;
         k++;
      end
      chk("settle_idle", 32'(busy), 32'h0);
      @(posedge clk); #2;
   endtask

   task automatic new_d();
      bus.d_req   = 1'b1;
      bus.d_we    = 1'($urandom_range(1, 0));
      bus.d_addr  = {24'h0, 6'($urandom_range(63, 0)), 2'b00};
      bus.d_wdata = $urandom;
   endtask

   task automatic new_i();
      bus.if_req  = 1'b1;
      bus.if_addr = {24'h0, 6'($urandom_range(63, 0)), 2'b00};
   endtask

   initial begin
      #1_000_000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   int lat, dlat, ilat, en_cnt, ack_cnt, dcnt, if_seen;

   initial begin
      for (int i = 0; i < 64; i++) begin
         env_mem[i] = init_word(i);
         ref_mem[i] = init_word(i);
      end
      env_mem[4] = 32'hDEAD_BEEF;
      ref_mem[4] = 32'hDEAD_BEEF;
      bus.if_req = 0; bus.if_addr = '0; bus.if_kill = 0;
      bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;

      repeat (3) @(posedge clk);
      #2;
      chk("reset_busy",   32'(busy),       32'h0);
      chk("reset_mem_en", 32'(bus.mem_en), 32'h0);
      chk("reset_d_ack",  32'(bus.d_ack),  32'h0);
      rst = 1'b1;
      @(posedge clk); #2;

      // single read of 0x10
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h10;
      @(posedge clk); #2;
      chk("rd_mem_en_t1", 32'(bus.mem_en), 32'h1);
      chk("rd_mem_we_t1", 32'(bus.mem_we), 32'h0);
      chk("rd_addr_t1",   bus.mem_addr,    32'h10);
      lat = 1;
      while (!bus.d_ack && (lat < 20)) begin
         @(posedge clk); #2;
         lat++;
      end
      chk("rd_ack_lat", 32'(lat), 32'd4);
      chk("rd_data",    bus.d_rdata, 32'hDEAD_BEEF);
      bus.d_req = 0;
      @(posedge clk); #2;
      chk("rd_busy_t5", 32'(busy), 32'h0);

      // write 0x1234 to 0x20
      settle();
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h20; bus.d_wdata = 32'h1234;
      @(posedge clk); #2;
      chk("wr_mem_en_t1", 32'(bus.mem_en), 32'h1);
      chk("wr_mem_we_t1", 32'(bus.mem_we), 32'h1);
      chk("wr_addr_t1",   bus.mem_addr,    32'h20);
      chk("wr_wdata_t1",  bus.mem_wdata,   32'h1234);
      @(posedge clk); #2;
      chk("wr_ack_t2",    32'(bus.d_ack),  32'h1);
      chk("wr_no_if_ack", 32'(bus.if_ack), 32'h0);
      bus.d_req = 0;

      // contention: data wins, fetch follows
      settle();
      bus.if_req = 1; bus.if_addr = 32'h44;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h10;
      dlat = 0; ilat = 0;
      for (int k = 1; (k <= 20) && (ilat == 0); k++) begin
         @(posedge clk); #2;
         if (bus.d_ack) begin dlat = k; bus.d_req = 0; end
         if (bus.if_ack) begin ilat = k; bus.if_req = 0; end
      end
      chk("cont_d_lat",   32'(dlat), 32'd4);
      chk("cont_if_lat",  32'(ilat), 32'd9);
      chk("cont_if_data", bus.if_rdata, init_word(17));

      // fetch of 0x40 killed in WAIT
      settle();
      bus.if_req = 1; bus.if_addr = 32'h40;
      en_cnt = 0; ack_cnt = 0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #2;
         if (bus.mem_en) en_cnt++;
         if (bus.if_ack) ack_cnt++;
         if (k == 2) bus.if_kill = 1;
         if (k == 3) begin bus.if_kill = 0; bus.if_req = 0; end
         if (k == 4) chk("kill_busy_t4", 32'(busy), 32'h1);
         if (k == 5) chk("kill_busy_t5", 32'(busy), 32'h0);
      end
      chk("kill_mem_en_cnt", 32'(en_cnt),  32'd1);
      chk("kill_if_ack_cnt", 32'(ack_cnt), 32'd0);
      chk("kill_if_rdata",   bus.if_rdata, init_word(17));

      // starvation: both held
      settle();
      bus.if_req = 1; bus.if_addr = 32'h48;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h10;
      dcnt = 0; if_seen = 0;
      for (int k = 1; (k <= 60) && (if_seen == 0); k++) begin
         @(posedge clk); #2;
         if (bus.d_ack) dcnt++;
         if (bus.if_ack) if_seen = 1;
      end
`ifdef ARB_IF_STARVE_GUARD_EN
      chk("starve_d_acks",  32'(dcnt),    32'd4);
      chk("starve_if_seen", 32'(if_seen), 32'd1);
`else
      chk("starve_d_acks",  32'(dcnt),    32'd12);
      chk("starve_if_seen", 32'(if_seen), 32'd0);
`endif

      // reset during WAIT
      settle();
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h24;
      @(posedge clk); #2;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("rst_busy",     32'(busy),       32'h0);
      chk("rst_mem_en",   32'(bus.mem_en), 32'h0);
      chk("rst_d_ack",    32'(bus.d_ack),  32'h0);
      chk("rst_mem_addr", bus.mem_addr,    32'h0);
      chk("rst_d_rdata",  bus.d_rdata,     32'h0);
      chk("rst_if_rdata", bus.if_rdata,    32'h0);
      bus.d_req = 0;
      #4;
      rst = 1'b1;
      @(posedge clk); #2;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h10;
      lat = 0;
      while (!bus.d_ack && (lat < 20)) begin
         @(posedge clk); #2;
         lat++;
      end
      chk("post_rst_lat",  32'(lat), 32'd4);
      chk("post_rst_data", bus.d_rdata, 32'hDEAD_BEEF);
      bus.d_req = 0;

      // randomized traffic, checked every cycle by the compare process
      settle();
      for (int k = 0; k < 3000; k++) begin
         @(posedge clk); #2;
         if (bus.d_req && bus.d_ack) begin
            if ($urandom_range(1, 0) == 1) new_d();
            else bus.d_req = 0;
         end else if (!bus.d_req && ($urandom_range(3, 0) == 0)) begin
            new_d();
         end
         if (bus.if_kill) begin
            bus.if_kill = 0;
            if ($urandom_range(1, 0) == 1) new_i();
            else bus.if_req = 0;
         end else if (bus.if_req && bus.if_ack) begin
            if ($urandom_range(1, 0) == 1) new_i();
            else bus.if_req = 0;
         end else if (bus.if_req && ($urandom_range(11, 0) == 0)) begin
            bus.if_kill = 1;
         end else if (!bus.if_req && ($urandom_range(2, 0) == 0)) begin
            new_i();
         end
      end
      settle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter that shares one single-ported, fixed-latency unified memory between the pipeline's instruction-fetch port and its data-memory port. It sits between the IF/MEM stages and the memory macro. It serialises requests into issue/wait/response sequences and returns one-cycle acknowledge pulses; the pipeline treats a missing acknowledge as a stall (IF holds the PC, MEM freezes EX/MEM).

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from the mem_en cycle to read data valid on mem_rdata (≥1)
- MAX_WAIT, 4, consecutive data grants tolerated while if_req pending (guard build only, ≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, held until if_ack or if_kill
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_kill  in  1  abandon the current or pending fetch (branch flush)
- if_ack  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  DATA_W  fetched word, held until next fetch ack
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_ack  out  1  one-cycle pulse
- d_rdata  out  DATA_W  read word, held until next data read ack
- mem_en  out  1  memory access strobe, exactly one cycle per transaction
- mem_we  out  1  write strobe, qualified by mem_en
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE: if d_req, grant D. Else if if_req && !if_kill, grant I. Else stay.
- On grant: latch owner, we (forced 0 for I), address and wdata; go to ISSUE.
- ISSUE: mem_en=1 and mem_we=latched we for this one cycle. A write goes next to RESP. A read loads wait_cnt=MEM_LAT and goes to WAIT.
- WAIT: wait_cnt decrements each cycle. On the cycle wait_cnt==1, capture mem_rdata into the owner's rdata register, then go to RESP.
- RESP: pulse the owner's ack, then always return to IDLE.
- if_kill while the owner is I (ISSUE/WAIT/RESP): the memory access still completes, but if_ack is suppressed and if_rdata is not updated. A kill flag is set and cleared on return to IDLE.
- if_kill never affects a D transaction. d_req never aborts.
- The inputs are sampled only at grant. Changes while busy are ignored.
- A requester may hold req high through its ack cycle to issue back-to-back. The request is re-arbitrated in the following IDLE cycle.
- Asynchronous reset mid-transaction: FSM returns to IDLE immediately and the in-flight access is dropped without ack. if_ack, d_ack, mem_en, mem_we and busy go to 0. mem_addr, mem_wdata, if_rdata and d_rdata go to 0. wait_cnt, starvation counter and kill flag go to 0.

## Timing
- Request seen in IDLE at cycle t: mem_en is high in cycle t+1.
- Read: ack at t+2+MEM_LAT (t+4 at default).
- Write: ack at t+2.
- Back-to-back throughput, one transaction per:
  - MEM_LAT+3 cycles for reads;
  - 3 cycles for writes.
- Simultaneous if_req and d_req in IDLE: D wins. I is granted at the next IDLE cycle unless d_req is still pending (see Configuration).
- if_kill and if_req asserted together in IDLE: no grant.

## Configuration
- ARB_IF_STARVE_GUARD_EN defined:
  - A saturating counter increments on each D grant made while if_req is pending.
  - It clears on any I grant, and clears while if_req is low.
  - When the counter reaches MAX_WAIT, the next IDLE decision grants I even if d_req is high.
- Undefined: strict data priority, and the counter logic is absent.

## Test plan
- Single read: d_req, d_we=0, addr 0x10, memory returns 0xDEADBEEF (MEM_LAT=2) -> mem_en in t+1, d_ack and d_rdata=0xDEADBEEF at t+4, busy low at t+5.
- Write: d_we=1, addr 0x20, data 0x1234 -> mem_en and mem_we high with addr 0x20 and data 0x1234 in t+1; d_ack at t+2; if_ack never pulses.
- Contention: if_req and d_req both held from t -> D served first (d_ack t+4). I is granted at t+5 and if_ack at t+9.
- Kill: fetch of 0x40 granted; if_kill pulsed in WAIT -> mem_en still pulses once, no if_ack, if_rdata keeps its old value, busy drops on schedule.
- Starvation (guard build, MAX_WAIT=4): d_req held high and if_req held -> exactly 4 d_acks, then an I grant and if_ack. Without the macro, if_ack never occurs while d_req is held.
- Reset: rst low during WAIT -> all outputs 0 in the same cycle. After release, a new read completes with normal latency.
